// File: rtl/simp_fun_pipe.sv
// simp_fun_pipe: mode-selectable unsigned arithmetic unit (add/sub/mul/max)
// with a LAT-deep elastic pipeline, valid/ready on both sides, per-result
// overflow flag, optional saturation and a delivered-result counter.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block accepts the input beat this cycle
//   a_in,b_in  unsigned operands
//   mode       0 add, 1 sub (a-b), 2 mul, 3 max; travels with the beat
//   out_valid  result valid
//   out_ready  sink accepts result
//   c_out      result
//   ovf_out    overflow/underflow for this result (regardless of SAT)
//   out_count  results delivered, wraps
module simp_fun_pipe #(
  parameter int WIDTH = 16,
  parameter int LAT   = 2,
  parameter int SAT   = 0,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c_out,
  output logic             ovf_out,
  output logic [CNT_W-1:0] out_count
);

  typedef struct packed {
    logic             ovf;
    logic [WIDTH-1:0] c;
  } res_t;

  localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

  // ---------------- datapath (feeds S1) ----------------
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [2*WIDTH-1:0] w_prod;
  res_t               w_res;

  assign w_sum  = {1'b0, a_in} + {1'b0, b_in};
  assign w_dif  = {1'b0, a_in} - {1'b0, b_in};
  assign w_prod = {{WIDTH{1'b0}}, a_in} * {{WIDTH{1'b0}}, b_in};

  always_comb begin
    w_res = '0;
    case (mode)
      2'd0: begin
        w_res.ovf = w_sum[WIDTH];
        w_res.c   = (SAT != 0 && w_sum[WIDTH]) ? MAXV : w_sum[WIDTH-1:0];
      end
      2'd1: begin
        w_res.ovf = (a_in < b_in);
        w_res.c   = (SAT != 0 && a_in < b_in) ? '0 : w_dif[WIDTH-1:0];
      end
      2'd2: begin
        w_res.ovf = |w_prod[2*WIDTH-1:WIDTH];
        w_res.c   = (SAT != 0 && w_res.ovf) ? MAXV : w_prod[WIDTH-1:0];
      end
      default: begin
        w_res.ovf = 1'b0;
        w_res.c   = (a_in >= b_in) ? a_in : b_in;
      end
    endcase
  end

  // ---------------- elastic pipeline ----------------
  res_t [LAT:1] r_dat;
  logic [LAT:1] r_vld;
  logic [LAT:1] w_adv;
  logic [CNT_W-1:0] r_cnt;

  // Advance chain walks from the sink back to S1; an empty stage always
  // advances, which is what lets bubbles collapse under a stall.
  always_comb begin
    logic acc;
    acc   = out_ready;
    w_adv = '0;
    for (int k = LAT; k >= 1; k--) begin
      acc      = !r_vld[k] || acc;
      w_adv[k] = acc;
    end
  end

  // Data registers load only with a valid beat, so X on idle operands never
  // enters the pipe, and the output stage keeps the last delivered result
  // while it is empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_dat <= '0;
      r_cnt <= '0;
    end else begin
      if (w_adv[1]) begin
        r_vld[1] <= in_valid;
        if (in_valid) r_dat[1] <= w_res;
      end
      for (int k = 2; k <= LAT; k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) r_dat[k] <= r_dat[k-1];
        end
      end
      if (r_vld[LAT] && out_ready) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_adv[1];
  assign out_valid = r_vld[LAT];
  assign c_out     = r_dat[LAT].c;
  assign ovf_out   = r_dat[LAT].ovf;
  assign out_count = r_cnt;

endmodule

// File: tb/tb_simp_fun_pipe.sv
// Directed bench for simp_fun_pipe: four builds share one stimulus stream
// (LAT=2/SAT=0 main, LAT=2/SAT=1, LAT=1, LAT=5); each check names its build.
module tb_simp_fun_pipe;

  logic        clk;
  logic        rst_n;
  logic        iv;
  logic        ordy;
  logic [15:0] a, b;
  logic [1:0]  md;

  logic        ir_m, ov_m, of_m;  logic [15:0] c_m;  logic [31:0] n_m;
  logic        ir_s, ov_s, of_s;  logic [15:0] c_s;  logic [31:0] n_s;
  logic        ir_1, ov_1, of_1;  logic [15:0] c_1;  logic [31:0] n_1;
  logic        ir_5, ov_5, of_5;  logic [15:0] c_5;  logic [31:0] n_5;

  int checks   = 0;
  int failures = 0;

  simp_fun_pipe #(.WIDTH(16), .LAT(2), .SAT(0), .CNT_W(32)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir_m), .a_in(a), .b_in(b),
    .mode(md), .out_valid(ov_m), .out_ready(ordy), .c_out(c_m), .ovf_out(of_m),
    .out_count(n_m));
  simp_fun_pipe #(.WIDTH(16), .LAT(2), .SAT(1), .CNT_W(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir_s), .a_in(a), .b_in(b),
    .mode(md), .out_valid(ov_s), .out_ready(ordy), .c_out(c_s), .ovf_out(of_s),
    .out_count(n_s));
  simp_fun_pipe #(.WIDTH(16), .LAT(1), .SAT(0), .CNT_W(32)) dut_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir_1), .a_in(a), .b_in(b),
    .mode(md), .out_valid(ov_1), .out_ready(ordy), .c_out(c_1), .ovf_out(of_1),
    .out_count(n_1));
  simp_fun_pipe #(.WIDTH(16), .LAT(5), .SAT(0), .CNT_W(32)) dut_5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir_5), .a_in(a), .b_in(b),
    .mode(md), .out_valid(ov_5), .out_ready(ordy), .c_out(c_5), .ovf_out(of_5),
    .out_count(n_5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] av, input logic [15:0] bv, input logic [1:0] mv);
    iv = 1'b1; a = av; b = bv; md = mv;
  endtask

  task automatic idle();
    iv = 1'b0; a = 'x; b = 'x; md = 'x;
  endtask

  initial begin
    int idx, nd;

    // ---- reset ----
    rst_n = 1'b0; ordy = 1'b1; idle();
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", ov_m, 0);
    chk("rst_c_out", c_m, 0);
    chk("rst_ovf", of_m, 0);
    chk("rst_count", n_m, 0);
    chk("rst_in_ready", ir_m, 1);

    // ---- back-to-back basic ops, out_ready=1 ----
    beat(5, 7, 0);      step();
    chk("b2b_lat2_not_yet", ov_m, 0);
    chk("b2b_lat1_valid", ov_1, 1);
    chk("b2b_lat1_c", c_1, 12);
    beat(10, 20, 0);    step();
    chk("b2b_r1_valid", ov_m, 1);
    chk("b2b_r1_c", c_m, 12);
    chk("b2b_r1_ovf", of_m, 0);
    beat(100, 50, 1);   step();
    chk("b2b_r2_c", c_m, 30);
    beat(100, 50, 3);   step();
    chk("b2b_r3_c", c_m, 50);
    chk("b2b_r3_sat_c", c_s, 50);
    idle();             step();
    chk("b2b_r4_valid", ov_m, 1);
    chk("b2b_r4_c", c_m, 100);
    chk("b2b_r4_ovf", of_m, 0);
    step();
    chk("b2b_drained", ov_m, 0);
    chk("b2b_hold_c", c_m, 100);
    chk("b2b_count", n_m, 4);
    chk("b2b_sat_count", n_s, 4);

    // ---- boundaries, wrap and saturate ----
    beat(65535, 1, 0);  step();
    beat(5, 7, 1);      step();
    chk("wrap_add_c", c_m, 0);       chk("wrap_add_ovf", of_m, 1);
    chk("sat_add_c", c_s, 65535);    chk("sat_add_ovf", of_s, 1);
    beat(300, 300, 2);  step();
    chk("wrap_sub_c", c_m, 65534);   chk("wrap_sub_ovf", of_m, 1);
    chk("sat_sub_c", c_s, 0);        chk("sat_sub_ovf", of_s, 1);
    idle();             step();
    chk("wrap_mul_c", c_m, 24464);   chk("wrap_mul_ovf", of_m, 1);
    chk("sat_mul_c", c_s, 65535);    chk("sat_mul_ovf", of_s, 1);
    step();
    chk("bound_count", n_m, 7);

    // ---- backpressure: 6 beats, sink stalled cycles 3..7 ----
    rst_n = 1'b0; step(); rst_n = 1'b1;
    idx = 0; nd = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      ordy = !(cyc >= 3 && cyc <= 7);
      if (idx < 6) beat(16'(idx + 1), 16'(10 * (idx + 1)), 0);
      else idle();
      #1;
      if (cyc == 3) chk("bp_full_in_ready", ir_m, 0);
      if (ov_m && !ordy) chk("bp_hold_c", c_m, 22);
      if (ov_m && ordy) begin
        chk("bp_order", c_m, 64'(11 * (nd + 1)));
        nd++;
      end
      if (iv && ir_m) idx++;
      step();
    end
    chk("bp_accepted", idx, 6);
    chk("bp_delivered", nd, 6);
    chk("bp_count", n_m, 6);

    // ---- bubbles collapse under stall ----
    ordy = 1'b0;
    beat(7, 8, 0);  step();
    idle();         step();
    beat(9, 9, 0);  #1;
    chk("bub_in_ready_with_hole", ir_m, 1);
    step();
    idle(); #1;
    chk("bub_full_in_ready", ir_m, 0);
    chk("bub_first_valid", ov_m, 1);
    chk("bub_first_c", c_m, 15);
    ordy = 1'b1;
    step();
    chk("bub_second_valid", ov_m, 1);
    chk("bub_second_c", c_m, 18);
    step();
    chk("bub_empty", ov_m, 0);
    chk("bub_count", n_m, 8);

    // ---- reset with beats in flight ----
    beat(1, 2, 0);  step();
    beat(3, 3, 0);  step();
    idle(); rst_n = 1'b0; step();
    rst_n = 1'b1; #1;
    chk("mid_rst_valid", ov_m, 0);
    chk("mid_rst_c", c_m, 0);
    chk("mid_rst_count", n_m, 0);
    chk("mid_rst_in_ready", ir_m, 1);
    beat(3, 4, 2);  step();
    idle();
    chk("mid_mul_not_yet", ov_m, 0);
    chk("mid_mul_lat1_c", c_1, 12);
    step();
    chk("mid_mul_valid", ov_m, 1);
    chk("mid_mul_c", c_m, 12);
    chk("mid_mul_ovf", of_m, 0);
    step();

    // ---- LAT=1 / LAT=5 latency with X on idle operands ----
    rst_n = 1'b0; step(); rst_n = 1'b1;
    idle(); step(); step();
    chk("x_idle_lat1_c", c_1, 0);
    chk("x_idle_lat5_c", c_5, 0);
    chk("x_idle_lat5_ovf", of_5, 0);
    beat(6, 7, 2); step();
    idle();
    for (int e = 1; e <= 7; e++) begin
      chk("x_lat1_valid", ov_1, (e == 1) ? 1 : 0);
      chk("x_lat1_c", c_1, 42);
      chk("x_lat5_valid", ov_5, (e == 5) ? 1 : 0);
      chk("x_lat5_c", c_5, (e >= 5) ? 42 : 0);
      chk("x_lat5_ovf", of_5, 0);
      step();
    end
    chk("x_lat5_count", n_5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
